// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA types for the pipeline front end.
// Fetch, fetch_buffer and decode all exchange fetch_entry_t.
package isa_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t pred_pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: bundle between fetch_buffer, decode and a bench.
// fb is the buffer side, dec the decode side, tb drives everything.
interface fetch_buffer_if #(
  parameter int DEPTH = 4
);
  import isa_pkg::*;

  localparam int PW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          enq_valid;
  word_t         enq_instr;
  word_t         enq_pc;
  word_t         enq_pred_pc;
  logic          enq_ready;
  logic          full;
  logic          deq_valid;
  logic          deq_ready;
  word_t         deq_instr;
  word_t         deq_pc;
  word_t         deq_pred_pc;
  logic [PW-1:0] count;

  modport fb (
    input  flush, enq_valid, enq_instr, enq_pc,
    input  enq_pred_pc, deq_ready,
    output enq_ready, full, deq_valid,
    output deq_instr, deq_pc, deq_pred_pc, count
  );

  modport dec (
    input  deq_valid, deq_instr, deq_pc,
    input  deq_pred_pc,
    output deq_ready
  );

  modport tb (
    output flush, enq_valid, enq_instr, enq_pc,
    output enq_pred_pc, deq_ready,
    input  enq_ready, full, deq_valid,
    input  deq_instr, deq_pc, deq_pred_pc, count
  );

endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order instruction queue from fetch to decode.
// Wrap-bit pointers, one-cycle flush, full drives fetch freeze.
module fetch_buffer
  import isa_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic                       enq_valid,
  input  word_t                      enq_instr,
  input  word_t                      enq_pc,
  input  word_t                      enq_pred_pc,
  output logic                       enq_ready,
  output logic                       full,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output word_t                      deq_instr,
  output word_t                      deq_pc,
  output word_t                      deq_pred_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  fetch_entry_t  mem_q [DEPTH];

  logic         empty;
  logic         enq_fire;
  logic         deq_fire;
  fetch_entry_t head_e;
  fetch_entry_t enq_e;

  assign empty = (head_q == tail_q);
  assign full  = (head_q[IW-1:0] == tail_q[IW-1:0])
              && (head_q[IW] != tail_q[IW]);
  assign count = tail_q - head_q;

  assign enq_ready = !full;
  assign deq_valid = !empty;

  assign enq_fire = enq_valid && enq_ready && !flush;
  assign deq_fire = deq_valid && deq_ready && !flush;

  assign enq_e = '{
    instr:   enq_instr,
    pc:      enq_pc,
    pred_pc: enq_pred_pc
  };

  assign head_e      = mem_q[head_q[IW-1:0]];
  assign deq_instr   = deq_valid ? head_e.instr   : '0;
  assign deq_pc      = deq_valid ? head_e.pc      : '0;
  assign deq_pred_pc = deq_valid ? head_e.pred_pc : '0;

  // Next pointers: flush empties the queue, else advance on fires.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PW'(1);
      if (deq_fire) head_d = head_q + PW'(1);
    end
  end

  // Pointer registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry storage; contents survive flush and reset.
  always_ff @(posedge CLK) begin
    if (nRST && enq_fire) begin
      mem_q[tail_q[IW-1:0]] <= enq_e;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed plan plus random traffic against a
// queue-based reference model of the fetch buffer.
module tb_fetch_buffer;
  import isa_pkg::*;

  localparam int DEPTH = 4;

  logic         clk;
  logic         n_rst;
  logic         flush;
  logic         enq_valid;
  word_t        enq_instr;
  word_t        enq_pc;
  word_t        enq_pred_pc;
  logic         enq_ready;
  logic         full;
  logic         deq_valid;
  logic         deq_ready;
  word_t        deq_instr;
  word_t        deq_pc;
  word_t        deq_pred_pc;
  logic [2:0]   count;

  fetch_entry_t mq[$];
  int           n_chk;
  int           n_fail;
  word_t        exp_pc;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .CLK         (clk),
    .nRST        (n_rst),
    .flush       (flush),
    .enq_valid   (enq_valid),
    .enq_instr   (enq_instr),
    .enq_pc      (enq_pc),
    .enq_pred_pc (enq_pred_pc),
    .enq_ready   (enq_ready),
    .full        (full),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_instr   (deq_instr),
    .deq_pc      (deq_pc),
    .deq_pred_pc (deq_pred_pc),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model queue.
  task automatic chk_all(input string tag);
    fetch_entry_t h;
    logic         v;
    v = (mq.size() != 0);
    h = v ? mq[0] : '0;
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".deq_valid"}, 32'(deq_valid), 32'(v));
    chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
    chk({tag, ".enq_ready"}, 32'(enq_ready),
        32'(mq.size() != DEPTH));
    chk({tag, ".deq_instr"}, deq_instr, h.instr);
    chk({tag, ".deq_pc"}, deq_pc, h.pc);
    chk({tag, ".deq_pred_pc"}, deq_pred_pc, h.pred_pc);
  endtask

  // Apply one cycle of inputs, step the model, check outputs.
  task automatic cyc(
    input string tag,
    input logic  rn,
    input logic  fl,
    input logic  ev,
    input word_t ins,
    input word_t pc,
    input logic  dr
  );
    int sz;
    fetch_entry_t e;
    n_rst       = rn;
    flush       = fl;
    enq_valid   = ev;
    enq_instr   = ins;
    enq_pc      = pc;
    enq_pred_pc = pc + 32'd4;
    deq_ready   = dr;
    e = '{instr: ins, pc: pc, pred_pc: pc + 32'd4};
    @(posedge clk);
    sz = mq.size();
    if (!rn || fl) begin
      mq.delete();
    end else begin
      if (dr && sz > 0) void'(mq.pop_front());
      if (ev && sz < DEPTH) mq.push_back(e);
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    n_rst = 1'b0; flush = 1'b0; enq_valid = 1'b0;
    enq_instr = '0; enq_pc = '0; enq_pred_pc = '0;
    deq_ready = 1'b0;

    // Reset held two cycles with enq_valid high.
    cyc("rst0", 1'b0, 1'b0, 1'b1, 32'h99, 32'h40, 1'b0);
    cyc("rst1", 1'b0, 1'b0, 1'b1, 32'h99, 32'h40, 1'b0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.enq_ready", 32'(enq_ready), 32'd1);
    chk("rst.deq_instr", deq_instr, 32'd0);

    // Fill to full, fifth enqueue refused.
    for (int i = 0; i < 4; i++)
      cyc("fill", 1'b1, 1'b0, 1'b1, 32'h11 * (i + 1),
          32'(i * 4), 1'b0);
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.count", 32'(count), 32'd4);
    cyc("fill5", 1'b1, 1'b0, 1'b1, 32'h55, 32'h10, 1'b0);
    chk("fill5.deq_instr", deq_instr, 32'h11);

    // Dequeue from full: same-cycle enqueue must not fire.
    cyc("fdq", 1'b1, 1'b0, 1'b1, 32'h55, 32'h10, 1'b1);
    chk("fdq.count", 32'(count), 32'd3);
    chk("fdq.deq_instr", deq_instr, 32'h22);
    cyc("fdq2", 1'b1, 1'b0, 1'b1, 32'h55, 32'h10, 1'b0);
    chk("fdq2.count", 32'(count), 32'd4);

    // Drain, then stream 10 entries across the pointer wrap.
    for (int i = 0; i < 4; i++)
      cyc("drain", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    exp_pc = 32'h0;
    for (int i = 0; i < 14; i++) begin
      if (deq_valid) begin
        chk("wrap.pc_order", deq_pc, exp_pc);
        exp_pc += 32'd4;
      end
      cyc("wrap", 1'b1, 1'b0, i < 10, 32'hA000 + 32'(i),
          32'(i * 4), i > 0);
      chk("wrap.count_le2", 32'(count <= 3'd2), 32'd1);
    end
    chk("wrap.all_seen", exp_pc, 32'h28);

    // Flush with 3 entries and both handshakes active.
    for (int i = 0; i < 3; i++)
      cyc("pfl", 1'b1, 1'b0, 1'b1, 32'hB0 + 32'(i),
          32'h80 + 32'(i * 4), 1'b0);
    cyc("flush", 1'b1, 1'b1, 1'b1, 32'hBF, 32'hFC, 1'b1);
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.deq_valid", 32'(deq_valid), 32'd0);
    cyc("pflq", 1'b1, 1'b0, 1'b1, 32'hC0, 32'h100, 1'b0);
    chk("pflq.deq_pc", deq_pc, 32'h100);

    // Reset mid-stream with 2 entries.
    cyc("mr", 1'b1, 1'b0, 1'b1, 32'hD1, 32'h104, 1'b0);
    cyc("mrr", 1'b0, 1'b0, 1'b1, 32'hD2, 32'h108, 1'b0);
    chk("mrr.count", 32'(count), 32'd0);
    chk("mrr.deq_pc", deq_pc, 32'd0);
    cyc("mra", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("mra.deq_valid", 32'(deq_valid), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc("rnd",
          $urandom_range(0, 49) != 0,
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 3) != 0,
          $urandom,
          $urandom & 32'hFFFF_FFFC,
          $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
